// File: rtl/sha256_uart_ctrl_if.sv
// Byte-stream and core-side bus of the UART SHA-256 message controller.
// master = the controller, slave = the UART / core environment around it.
interface sha256_uart_ctrl_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         core_init;
  logic [511:0] core_block;
  logic         core_ready;
  logic         core_digest_valid;
  logic [255:0] core_digest;
  logic         busy;

  modport master (
    input  rx_data, rx_valid, tx_busy, core_ready, core_digest_valid, core_digest,
    output tx_data, tx_start, core_init, core_block, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, core_ready, core_digest_valid, core_digest,
    input  tx_data, tx_start, core_init, core_block, busy
  );
endinterface

// File: rtl/sha256_uart_ctrl.sv
// Length-prefixed single-block SHA-256 request/response controller.
// Optional inter-byte receive timeout: define SHA_CTRL_RX_TIMEOUT_EN.
module sha256_uart_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  sha256_uart_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PAD, S_START, S_WAIT, S_SEND, S_SKIP, S_SWAIT, S_ERR
  } state_t;

  localparam logic [7:0] MAX_LEN  = 8'd55;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  state_t       state, state_nxt;
  logic [5:0]   len;
  logic [5:0]   idx;
  logic [5:0]   cnt;
  logic [511:0] block;
  logic [255:0] shreg;
  logic         timeout;

`ifdef SHA_CTRL_RX_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  to_cnt <= '0;
    else if (state != S_LOAD || bus.rx_valid) to_cnt <= '0;
    else                                      to_cnt <= to_cnt + 32'd1;
  end

  // Fires on the idle LOAD cycle in which the counter would reach the limit.
  assign timeout = (state == S_LOAD) && !bus.rx_valid && (to_cnt == TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_nxt     = state;
    bus.tx_start  = 1'b0;
    bus.core_init = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data > MAX_LEN)    state_nxt = S_ERR;
          else if (bus.rx_data == 8'd0) state_nxt = S_PAD;
          else                          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.rx_valid) begin
          if (idx + 6'd1 == len) state_nxt = S_PAD;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_PAD:   state_nxt = S_START;
      S_START: begin
        if (bus.core_ready) begin
          bus.core_init = 1'b1;
          state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.core_digest_valid) state_nxt = S_SEND;
      end
      // ERR is a one-byte SEND: its byte is already at the top of the shifter.
      S_SEND, S_ERR: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_nxt    = S_SKIP;
        end
      end
      // tx_busy only rises the cycle after tx_start, so it is not looked at here.
      S_SKIP:  state_nxt = S_SWAIT;
      S_SWAIT: begin
        if (!bus.tx_busy) state_nxt = (cnt == 6'd31) ? S_IDLE : S_SEND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the block buffer is plain flops with a defined reset value, not a RAM, so it is reset.
      len   <= '0;
      idx   <= '0;
      cnt   <= '0;
      block <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data > MAX_LEN) begin
              shreg <= {ERR_BYTE, 248'd0};
            end else begin
              block <= '0;
              len   <= bus.rx_data[5:0];
              idx   <= '0;
            end
          end
        end
        S_LOAD: begin
          if (bus.rx_valid) begin
            block[9'd511 - {idx, 3'b000} -: 8] <= bus.rx_data;
            idx                                <= idx + 6'd1;
          end else if (timeout) begin
            shreg <= {ERR_BYTE, 248'd0};
          end
        end
        S_PAD: begin
          block[9'd511 - {len, 3'b000} -: 8] <= 8'h80;
          block[15:0]                        <= {7'd0, len, 3'b000};
        end
        S_WAIT: begin
          if (bus.core_digest_valid) begin
            shreg <= bus.core_digest;
            cnt   <= '0;
          end
        end
        // Preloading cnt makes the single error byte also the last byte.
        S_ERR: begin
          if (!bus.tx_busy) cnt <= 6'd31;
        end
        S_SWAIT: begin
          if (!bus.tx_busy) begin
            cnt   <= cnt + 6'd1;
            shreg <= {shreg[247:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

  // tx_data is the shifter's top byte, so it holds until the post-byte shift.
  assign bus.tx_data    = shreg[255:248];
  assign bus.core_block = block;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: doc/sha256_uart_ctrl.md
# sha256_uart_ctrl

Message controller between the UART byte streams and the SHA-256 compression core inside the UART SHA-256 top level. It collects a length-prefixed message from the UART receiver and builds the single padded 512-bit block. It then starts the core, waits for the digest, and serialises the 32 digest bytes to the UART transmitter. The core is only ever driven by this block; the host sees a simple request/response byte protocol.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between message bytes before abort; used only when the timeout feature is compiled in.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte from UART RX.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  one-cycle strobe requesting transmission of `tx_data`.
- `tx_busy`  in  1  UART TX busy; rises the cycle after `tx_start`, falls when the byte is done.
- `core_init`  out  1  one-cycle strobe starting a fresh hash on `core_block`.
- `core_block`  out  512  padded block; byte 0 in bits [511:504].
- `core_ready`  in  1  core idle and able to accept `core_init`.
- `core_digest_valid`  in  1  level; digest available.
- `core_digest`  in  256  result; byte 0 in bits [255:248].
- `busy`  out  1  high in every state except IDLE.

## Operation
- Protocol: host sends length byte N, then N message bytes. The controller answers with 32 digest bytes, MSB byte first. A single block only, so N must be in 0..55.
- States:
  - IDLE: wait for `rx_valid`. If N > 55 go to ERR; if N = 0 go to PAD; otherwise clear the buffer, set idx = 0 and go to LOAD.
  - LOAD: each `rx_valid` writes `rx_data` to buffer byte idx and increments idx. When idx reaches N, go to PAD.
  - PAD: one cycle. Write byte N = 0x80. Bytes N+1..61 stay 0x00. Bytes 62..63 = N*8 as 16-bit big-endian; bytes 56..61 = 0. Go to START.
  - START: when `core_ready` is high, pulse `core_init` for one cycle, then go to WAIT.
  - WAIT: when `core_digest_valid` is high, capture `core_digest` into the output shift register, set cnt = 0 and go to SEND.
  - SEND: when `tx_busy` is low, drive `tx_data` with digest byte cnt, pulse `tx_start` and go to SWAIT.
  - SWAIT: skip one cycle, then wait for `tx_busy` low. Increment cnt; if cnt = 32 go to IDLE, else go to SEND.
  - ERR: transmit a single byte 0xEE using the SEND/SWAIT handshake, then go to IDLE.
- `rx_valid` outside IDLE and LOAD is dropped; no buffering and no error.
- `core_block` is a register and stays stable from PAD until the next message.
- Arithmetic widths: idx is 6 bits and cnt is 6 bits. The length field is computed as {N, 3'b000} zero-extended to 16 bits.

## Timing
- Reset values: `tx_start` = 0, `tx_data` = 0x00, `core_init` = 0, `core_block` = 0, `busy` = 0, state = IDLE, all counters = 0.
- A reset asserted in any state takes effect immediately (asynchronous). Any in-flight message or digest is discarded, and no partial output is completed after reset is released.
- Latency from the last message byte's `rx_valid` to `core_init`:
  - 2 cycles (LOAD→PAD→START) when `core_ready` is already high.
  - Otherwise `core_init` fires in the first cycle that `core_ready` is high.
- The first `tx_start` fires one cycle after WAIT sees `core_digest_valid`, provided `tx_busy` is low.
- `core_init` and `tx_start` are never high for two consecutive cycles.
- A simultaneous `rx_valid` in the cycle LOAD→PAD occurs cannot happen: the transition is taken on the strobe that completes the message.

## Configuration
- `SHA_CTRL_RX_TIMEOUT_EN` defined:
  - A counter clears on each `rx_valid` and increments every LOAD cycle without one.
  - When it reaches `TIMEOUT_CYCLES`, the partial message is discarded and the controller goes to ERR, which sends 0xEE.
  - The counter is held at 0 outside LOAD.
- `SHA_CTRL_RX_TIMEOUT_EN` undefined:
  - No counter logic is synthesised and `TIMEOUT_CYCLES` is unused.
  - LOAD waits indefinitely for the remaining bytes.

## Test plan
- "abc" case:
  - Send 0x03, 0x61, 0x62, 0x63.
  - `core_block` = 616263 80 00…00 0018.
  - The 32 TX bytes are ba 78 16 bf … f2 00 15 ad.
- Empty message:
  - Send 0x00.
  - `core_block` = 80 00…00 0000.
  - TX begins e3 b0 c4 42 and ends 78 52 b8 55.
- Over-length:
  - Send 0x38 (56).
  - Exactly one TX byte 0xEE, no `core_init`, back to IDLE with `busy` = 0.
- Backpressure:
  - Hold `core_ready` low for 50 cycles after "abc".
  - `core_init` fires in the cycle `core_ready` rises.
  - `tx_start` never fires while `tx_busy` is high; the 32 bytes are transmitted in order.
- Reset mid-operation:
  - Assert `rst` during SEND after 10 bytes.
  - All outputs go to reset values at once; after release, a new "abc" request returns the full correct digest.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 100):
  - Send 0x05, 0x41, then nothing.
  - 0xEE is sent about 100 cycles later.
  - A following "abc" request hashes correctly.
